// File: rtl/csv_sfifo_ram_fwft.sv
// ============================================================================
// Module   : csv_sfifo_ram_fwft
// Brief    : Synchronous FIFO on a 1R1W RAM with a 1-cycle registered read.
//            The read port is first-word-fall-through with valid/ready
//            handshake and sustains one pop per cycle. A level count and
//            almost-full / almost-empty flags are also provided.
//            Optional macro CSV_SFIFO_ERR_EN builds sticky overflow and
//            underflow detection; without it both flags are tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csv_sfifo_ram_fwft #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int CNT_WIDTH     = $clog2(DEPTH + 1),
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic                 i_wreq,
  output logic                 o_wready,
  output logic [WIDTH-1:0]     o_rdata,
  output logic                 o_rvalid,
  input  logic                 i_rreq,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_afull,
  output logic                 o_aempty,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  c_depth     = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  c_afull     = CNT_WIDTH'(AFULL_THRESH);
  localparam logic [CNT_WIDTH-1:0]  c_aempty    = CNT_WIDTH'(AEMPTY_THRESH);

  // Storage array; no reset so it can map onto a RAM macro.
  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  // count_q: every word held; ram_cnt_q: words still sitting in the array.
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  ram_cnt_q, ram_cnt_d;

  // RAM read register; its content is a live word while infl_q is set.
  logic [WIDTH-1:0]      ram_rdata_q;
  logic                  infl_q;

  // Output stage: head is the oldest buffered word, skid the next one.
  logic [WIDTH-1:0]      head_q, head_d, skid_q, skid_d;
  logic                  head_v_q, head_v_d, skid_v_q, skid_v_d;

  logic                  w_full;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_rvalid;
  logic                  w_issue;
  logic [WIDTH-1:0]      w_first;
  logic [WIDTH-1:0]      w_second;
  logic                  w_second_v;
  logic [1:0]            w_occ_after;

  assign w_full   = (count_q == c_depth);
  assign w_wr     = i_wreq & ~w_full;

  // The in-flight word is presented directly, which gives the 2-cycle
  // write-to-valid latency without an extra register stage.
  assign w_rvalid = head_v_q | infl_q;
  assign w_first  = head_v_q ? head_q : ram_rdata_q;
  assign w_pop    = i_rreq & w_rvalid;

  // Second-oldest word: skid if present, otherwise the arriving RAM word.
  assign w_second   = skid_v_q ? skid_q : ram_rdata_q;
  assign w_second_v = head_v_q & (skid_v_q | infl_q);

  // Occupancy seen after this cycle's pop; counting the pop lets a read
  // issue every cycle while popping, so there is no bubble.
  assign w_occ_after = 2'(head_v_q) + 2'(skid_v_q) + 2'(infl_q) - 2'(w_pop);
  assign w_issue     = (ram_cnt_q != '0) && (w_occ_after < 2'd2);

  // Output-stage next state: drop the head on pop, compact the rest.
  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (w_pop) begin
      head_d   = w_second;
      head_v_d = w_second_v;
      skid_v_d = 1'b0;
    end else begin
      head_d   = w_first;
      head_v_d = w_rvalid;
      skid_d   = w_second;
      skid_v_d = w_second_v;
    end
  end

  // Level bookkeeping: total words and words still in the array.
  always_comb begin
    count_d   = count_q;
    ram_cnt_d = ram_cnt_q;
    case ({w_wr, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case ({w_wr, w_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  // Pointers, levels, read register and output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ram_cnt_q   <= '0;
      ram_rdata_q <= '0;
      infl_q      <= 1'b0;
      head_q      <= '0;
      head_v_q    <= 1'b0;
      skid_q      <= '0;
      skid_v_q    <= 1'b0;
    end else begin
      if (w_wr) begin
        wr_ptr_q <= (wr_ptr_q == c_last_addr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_issue) begin
        rd_ptr_q    <= (rd_ptr_q == c_last_addr) ? '0 : rd_ptr_q + 1'b1;
        ram_rdata_q <= mem_q[rd_ptr_q];
      end
      infl_q    <= w_issue;
      count_q   <= count_d;
      ram_cnt_q <= ram_cnt_d;
      head_q    <= head_d;
      head_v_q  <= head_v_d;
      skid_q    <= skid_d;
      skid_v_q  <= skid_v_d;
    end
  end

`ifdef CSV_SFIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  // Sticky error capture: write while full, read while nothing valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (i_wreq & w_full) begin
        ovf_q <= 1'b1;
      end
      if (i_rreq & ~w_rvalid) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  assign o_wready = ~w_full;
  assign o_full   = w_full;
  assign o_empty  = (count_q == '0);
  assign o_afull  = (count_q >= c_afull);
  assign o_aempty = (count_q <= c_aempty);
  assign o_count  = count_q;
  assign o_rvalid = w_rvalid;
  assign o_rdata  = w_first;

endmodule

`default_nettype wire
